// File: rtl/board_io_conditioner.sv
// Board-level conditioner: button sync/debounce with edge pulses, heartbeat,
// press counter and a registered 16-LED page multiplexer.
module board_io_conditioner #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HB_HALF_PERIOD  = 10_000_000,
    parameter int unsigned PAGE_BTN        = 0
) (
    input  logic               clk_100mhz,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [15:0]        status_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               heartbeat,
    output logic [1:0]         page,
    output logic [15:0]        led
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HB_W = $clog2(HB_HALF_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        PgStatus = 2'd0,
        PgDebug  = 2'd1,
        PgCount  = 2'd2,
        PgWalk   = 2'd3
    } page_e;

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] btn_sync;
    logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
    logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [HB_W-1:0]    hb_cnt_q;
    logic               hb_q;
    logic               hb_wrap;
    logic [15:0]        press_cnt_q;
    logic [15:0]        walk_q;
    page_e              page_q, page_d;
    logic [15:0]        led_q, led_d;
    logic [7:0]         level8;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // A level change needs DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            db_cnt_d[b] = '0;
            if (btn_sync[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b]   = btn_sync[b];
                    press_d[b]   = btn_sync[b];
                    release_d[b] = ~btn_sync[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign hb_wrap = (hb_cnt_q == HB_LAST);

    always_comb begin
        page_d = page_q;
        if (press_q[PAGE_BTN]) begin
            unique case (page_q)
                PgStatus: page_d = PgDebug;
                PgDebug:  page_d = PgCount;
                PgCount:  page_d = PgWalk;
                PgWalk:   page_d = PgStatus;
            endcase
        end
    end

    always_comb begin
        level8                 = '0;
        level8[NUM_BTN-1:0]    = level_q;
        led_d                  = '0;
        unique case (page_q)
            PgStatus: led_d = status_in;
            PgDebug:  led_d = {hb_q, page_q, press_cnt_q[4:0], level8};
            PgCount:  led_d = press_cnt_q;
            PgWalk:   led_d = walk_q;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            hb_cnt_q    <= '0;
            hb_q        <= 1'b0;
            press_cnt_q <= '0;
            walk_q      <= 16'h0001;
            page_q      <= PgStatus;
            led_q       <= '0;
        end else begin
            for (int b = 0; b < NUM_BTN; b++) db_cnt_q[b] <= db_cnt_d[b];
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            if (hb_wrap) begin
                hb_cnt_q <= '0;
                hb_q     <= ~hb_q;
                walk_q   <= {walk_q[14:0], walk_q[15]};
            end else begin
                hb_cnt_q <= hb_cnt_q + 1'b1;
            end
            // Simultaneous presses count once.
            if (|press_q) press_cnt_q <= press_cnt_q + 16'd1;
            page_q <= page_d;
            led_q  <= led_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign heartbeat   = hb_q;
    assign page        = page_q;
    assign led         = led_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Bench for board_io_conditioner: vector table, directed corner sequences and
// randomized stimulus against a window-based behavioural model.
module tb_board_io_conditioner;

    localparam int unsigned NB = 5;
    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;
    localparam int unsigned HB = 8;

    logic          clk_100mhz = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [15:0]   status_in = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          heartbeat;
    logic [1:0]    page;
    logic [15:0]   led;

    always #5 clk_100mhz = ~clk_100mhz;

    board_io_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .HB_HALF_PERIOD (HB),
        .PAGE_BTN       (0)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .status_in  (status_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .heartbeat  (heartbeat),
        .page       (page),
        .led        (led)
    );

    int n_vec = 0;
    int n_err = 0;
    int press_seen [NB];
    int rel_seen   [NB];

    // Model: level flips once the last DC synchronised samples all disagree.
    int            hb_n;
    logic [NB-1:0] m_level, m_press, m_release;
    logic          m_hb;
    logic [1:0]    m_page;
    logic [15:0]   m_cnt, m_walk, m_led;
    logic [NB-1:0] raw_dly [$];
    logic [NB-1:0] hist    [$];

    function automatic void model_reset();
        hb_n = 0; m_hb = 1'b0; m_walk = 16'h0001; m_cnt = '0; m_page = '0; m_led = '0;
        m_level = '0; m_press = '0; m_release = '0;
        raw_dly.delete();
        for (int i = 0; i < SS; i++) raw_dly.push_back('0);
        hist.delete();
    endfunction

    function automatic void model_edge();
        logic [15:0]   nled;
        logic [NB-1:0] s;
        logic          all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_page)
            2'd0:    nled = status_in;
            2'd1:    nled = {m_hb, m_page, m_cnt[4:0], 3'b000, m_level};
            2'd2:    nled = m_cnt;
            default: nled = m_walk;
        endcase
        if (m_press[0]) m_page = m_page + 2'd1;
        if (m_press != '0) m_cnt = m_cnt + 16'd1;
        hb_n++;
        m_hb   = ((hb_n / HB) % 2) == 1;
        m_walk = 16'h0001 << ((hb_n / HB) % 16);
        raw_dly.push_back(btn_raw);
        s = raw_dly.pop_front();
        hist.push_back(s);
        if (hist.size() > DC) void'(hist.pop_front());
        m_press = '0;
        m_release = '0;
        if (hist.size() == DC) begin
            for (int b = 0; b < NB; b++) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) m_press[b] = 1'b1;
                    else m_release[b] = 1'b1;
                end
            end
        end
        m_led = nled;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_seen();
        for (int b = 0; b < NB; b++) begin
            press_seen[b] = 0;
            rel_seen[b]   = 0;
        end
    endtask

    task automatic step(input logic r, input logic [NB-1:0] raw, input logic [15:0] st);
        @(negedge clk_100mhz);
        rst = r;
        btn_raw = raw;
        status_in = st;
        @(posedge clk_100mhz);
        model_edge();
        #1;
        for (int b = 0; b < NB; b++) begin
            press_seen[b] += int'(btn_press[b]);
            rel_seen[b]   += int'(btn_release[b]);
        end
        check("outputs", 64'({btn_level, btn_press, btn_release, heartbeat, page, led}),
              64'({m_level, m_press, m_release, m_hb, m_page, m_led}));
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        clr_seen();
    endtask

    task automatic press_btn(input logic [NB-1:0] mask);
        for (int i = 0; i < 6; i++) step(1'b0, mask, 16'h0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 16'h0);
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        logic [15:0]   st;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [15:0]   led;
    } vec_t;

    vec_t tab [15];
    logic [1:0] exp_pages [5];
    logic       saw_8000;
    int         hold [NB];
    logic [NB-1:0] rnd_raw;

    initial begin
        // Clean press/release on btn 1, page 0 so led echoes status_in.
        tab[0]  = '{5'b00010, 16'h1111, 5'b00000, 5'b00000, 5'b00000, 16'h1111};
        tab[1]  = '{5'b00010, 16'h2222, 5'b00000, 5'b00000, 5'b00000, 16'h2222};
        tab[2]  = '{5'b00010, 16'h3333, 5'b00000, 5'b00000, 5'b00000, 16'h3333};
        tab[3]  = '{5'b00010, 16'h4444, 5'b00000, 5'b00000, 5'b00000, 16'h4444};
        tab[4]  = '{5'b00010, 16'h5555, 5'b00000, 5'b00000, 5'b00000, 16'h5555};
        tab[5]  = '{5'b00010, 16'hA5A5, 5'b00010, 5'b00010, 5'b00000, 16'hA5A5};
        tab[6]  = '{5'b00010, 16'h5A5A, 5'b00010, 5'b00000, 5'b00000, 16'h5A5A};
        tab[7]  = '{5'b00010, 16'hFFFF, 5'b00010, 5'b00000, 5'b00000, 16'hFFFF};
        tab[8]  = '{5'b00000, 16'h0001, 5'b00010, 5'b00000, 5'b00000, 16'h0001};
        tab[9]  = '{5'b00000, 16'h0002, 5'b00010, 5'b00000, 5'b00000, 16'h0002};
        tab[10] = '{5'b00000, 16'h0004, 5'b00010, 5'b00000, 5'b00000, 16'h0004};
        tab[11] = '{5'b00000, 16'h0008, 5'b00010, 5'b00000, 5'b00000, 16'h0008};
        tab[12] = '{5'b00000, 16'h0010, 5'b00010, 5'b00000, 5'b00000, 16'h0010};
        tab[13] = '{5'b00000, 16'h0020, 5'b00000, 5'b00000, 5'b00010, 16'h0020};
        tab[14] = '{5'b00000, 16'h0040, 5'b00000, 5'b00000, 5'b00000, 16'h0040};
        exp_pages = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();
        check("reset_state", 64'({btn_level, btn_press, btn_release, heartbeat, page, led}),
              64'(0));
        check("reset_walk", 64'(dut.walk_q), 64'h0001);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, tab[i].raw, tab[i].st);
            check("tab_row", 64'({btn_level, btn_press, btn_release, led}),
                  64'({tab[i].lvl, tab[i].prs, tab[i].rel, tab[i].led}));
        end
        for (int i = 0; i < 25; i++) step(1'b0, '0, 16'h0);
        check("clean_press_count", 64'(press_seen[1]), 64'd1);
        check("clean_release_count", 64'(rel_seen[1]), 64'd1);
        check("clean_press_cnt", 64'(dut.press_cnt_q), 64'd1);

        // Bounce: 3 high samples then 1 low never reaches the debounce length.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b0, (i % 4 != 3) ? 5'b00100 : 5'b00000, 16'h0);
        check("bounce_level", 64'(btn_level[2]), 64'd0);
        check("bounce_pulses", 64'(press_seen[2] + rel_seen[2]), 64'd0);
        check("bounce_press_cnt", 64'(dut.press_cnt_q), 64'd0);

        // Page cycling.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            press_btn(5'b00001);
            check("page_seq", 64'(page), 64'(exp_pages[p]));
            if (p == 1) check("page2_led_cnt", 64'(led), 64'd2);
        end

        // Heartbeat and walk.
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            step(1'b0, '0, 16'h0);
            if (k % 8 == 0 || k % 8 == 7) check("hb_edge", 64'(heartbeat), 64'((k / 8) % 2));
        end
        check("walk_8_toggles", 64'(dut.walk_q), 64'h0100);
        saw_8000 = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step(1'b0, '0, 16'h0);
            if (dut.walk_q == 16'h8000) saw_8000 = 1'b1;
        end
        check("walk_saw_8000", 64'(saw_8000), 64'd1);
        check("walk_wrap", 64'(dut.walk_q), 64'h0001);

        // Counter wrap with a simultaneous double press.
        do_reset();
        force dut.press_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(1'b0, '0, 16'h0);
        release dut.press_cnt_q;
        check("cnt_preload", 64'(dut.press_cnt_q), 64'hFFFF);
        press_btn(5'b11000);
        check("cnt_wrap", 64'(dut.press_cnt_q), 64'h0000);
        check("dual_press", 64'({press_seen[3], press_seen[4]}), {32'd1, 32'd1});

        // Reset mid-debounce while on page 2 with btn 1 held.
        do_reset();
        press_btn(5'b00001);
        press_btn(5'b00001);
        check("pre_rst_page", 64'(page), 64'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b00010, 16'h0);
        step(1'b1, 5'b00010, 16'hBEEF);
        check("mid_rst_outputs",
              64'({btn_level, btn_press, btn_release, heartbeat, page, led}), 64'(0));
        check("mid_rst_walk", 64'(dut.walk_q), 64'h0001);
        clr_seen();
        for (int i = 0; i < 20; i++) step(1'b0, 5'b00010, 16'h0);
        check("held_repress", 64'(press_seen[1]), 64'd1);
        check("held_level", 64'(btn_level[1]), 64'd1);

        // Randomized holds of 1..7 cycles mix bounces with clean edges.
        do_reset();
        for (int b = 0; b < NB; b++) hold[b] = 0;
        rnd_raw = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (hold[b] == 0) begin
                    rnd_raw[b] = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 7));
                end
                hold[b]--;
            end
            step(($urandom_range(0, 199) == 0), rnd_raw, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_io_conditioner.md
# board_io_conditioner

Board-level input/status conditioner for the Basys3 TPU bring-up builds. It provides:
- Per-button synchronisation, debouncing and press/release pulses for up to 8 buttons.
- A clean-period heartbeat.
- A registered 16-LED page multiplexer, with pages advanced by a selectable button.

It sits between the board pins and the TPU core, and supersedes the ad-hoc single-button and heartbeat logic in the bring-up top-levels.

## Interface
- NUM_BTN, 5: number of buttons; legal range 1..8.
- SYNC_STAGES, 2: synchroniser flops per button; minimum 2.
- DEBOUNCE_CYCLES, 1_000_000: required stable cycles before a level change (10 ms); minimum 2.
- HB_HALF_PERIOD, 10_000_000: heartbeat half-period in cycles; minimum 2.
- PAGE_BTN, 0: button index whose press advances the LED page; must be < NUM_BTN.

- clk_100mhz, in, 1: system clock.
- rst, in, 1: reset; synchronous, active-high; clock clk_100mhz.
- btn_raw, in, NUM_BTN: asynchronous button pins.
- status_in, in, 16: user status word shown on page 0.
- btn_level, out, NUM_BTN: debounced button levels.
- btn_press, out, NUM_BTN: one-cycle pulse per debounced rising edge.
- btn_release, out, NUM_BTN: one-cycle pulse per debounced falling edge.
- heartbeat, out, 1: square wave with period 2*HB_HALF_PERIOD cycles.
- page, out, 2: current LED page.
- led, out, 16: registered LED drive.

## Operation
- **Synchroniser:** SYNC_STAGES flops per bit, all cleared by rst.
- **Debouncer, per button:** a counter of width clog2(DEBOUNCE_CYCLES).
  - Sync output equals btn_level: counter clears to 0.
  - Sync output differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Sync output differs and counter == DEBOUNCE_CYCLES-1: btn_level flips, counter clears, and btn_press (new level 1) or btn_release (new level 0) asserts for exactly that cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no event.
- **Heartbeat:** hb_cnt counts 0..HB_HALF_PERIOD-1. When hb_cnt == HB_HALF_PERIOD-1, heartbeat toggles and hb_cnt returns to 0.
- **Press counter:** press_cnt is 16 bits. It increments by 1 in any cycle where |btn_press is set; simultaneous presses count once. It wraps 16'hFFFF -> 16'h0000.
- **Page FSM:** 4 states, PG_STATUS(0) -> PG_DEBUG(1) -> PG_COUNT(2) -> PG_WALK(3) -> PG_STATUS. Advances only on btn_press[PAGE_BTN]; holds otherwise.
- **Walk pattern:** a 16-bit one-hot register. It rotates left by 1 on every heartbeat toggle; bit15 wraps to bit0. It runs regardless of the current page.
- **led (registered) by page:**
  - PG_STATUS: status_in.
  - PG_DEBUG: led[15]=heartbeat, led[14:13]=page, led[12:8]=press_cnt[4:0], led[7:0]=btn_level zero-extended.
  - PG_COUNT: press_cnt.
  - PG_WALK: walk register.
- **Reset values** (rst sampled high clears everything, including mid-debounce and mid-count):
  - btn_level, btn_press, btn_release: 0.
  - heartbeat 0, hb_cnt 0, press_cnt 0.
  - page 0, walk 16'h0001, led 16'h0000.
  - All synchroniser flops and debounce counters: 0.
- **Reset with a button held:** the button stays held, so after release of rst a press event is generated once debouncing completes.

## Timing
- **btn_raw to btn_level latency:** SYNC_STAGES + DEBOUNCE_CYCLES edges, counted from the first edge that samples the new raw value. With 2/4, raw stable from edge 1 gives btn_level at edge 6.
- **Event pulses:** btn_press and btn_release are high in the same cycle btn_level first shows the new value, for 1 cycle only.
- **Page advance:** page updates on the edge after btn_press[PAGE_BTN] is high.
- **led:** reflects page and source values one edge later, so led lags page by 1 cycle.
- **heartbeat:** first toggle at edge HB_HALF_PERIOD after rst deasserts; toggles thereafter every HB_HALF_PERIOD edges.
- **Simultaneous page-button press and rst:** rst wins.

## Test plan
All scenarios use NUM_BTN=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HB_HALF_PERIOD=8, PAGE_BTN=0.

1. **Clean press/release.** Hold btn_raw[1]=1 for 20 cycles, then 0 for 20.
   - btn_level[1] rises 6 edges after the first 1 sample, with a single btn_press[1] pulse.
   - Falls 6 edges after the first 0 sample, with a single btn_release[1] pulse.
   - press_cnt ends at 1.
2. **Bounce rejection.** btn_raw[2] toggles 1,1,1,0 repeatedly for 40 cycles.
   - btn_level[2] stays 0.
   - No pulses; press_cnt stays 0.
3. **Page cycling.** Apply 5 clean presses on btn_raw[0].
   - page goes 1,2,3,0,1.
   - On page 2, led equals press_cnt, with led lagging page by 1 cycle.
4. **Heartbeat and walk.** Run 64 cycles after reset.
   - heartbeat toggles at edges 8,16,...
   - walk steps 0001 -> 0002 -> ... and reaches 0100 after 8 toggles.
   - Force 16 toggles and check the wrap 8000 -> 0001.
5. **Counter wrap and simultaneous events.**
   - Preload press_cnt to FFFF via 65535 presses, or via a force in simulation. Then press btn[3] and btn[4] in the same cycle: press_cnt becomes 0000.
6. **Reset mid-operation.** Assert rst for 1 cycle during a debounce count and on page 2.
   - All outputs return to their reset values (led 0000, page 0, walk 0001).
   - A held button re-debounces and produces exactly one btn_press after rst deasserts.
